// File: rtl/neuron_layer_mac_if.sv
// Request/result bundle for neuron_layer_mac: latched operands in, one activated
// result per neuron out with valid/ready flow control.
interface neuron_layer_mac_if #(
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned X_W         = 8,
    parameter int unsigned W_W         = 8,
    parameter int unsigned B_W         = 32,
    parameter int unsigned OUT_W       = 16
);
    localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                                in_valid;
    logic                                in_ready;
    logic [NUM_NEURONS*B_W-1:0]          bias_flat;
    logic [NUM_INPUTS*X_W-1:0]           x_flat;
    logic [NUM_NEURONS*NUM_INPUTS*W_W-1:0] w_flat;
    logic [1:0]                          act_sel;
    logic [NUM_INPUTS-1:0]               mask_flat;
    logic                                out_valid;
    logic                                out_ready;
    logic [OUT_W-1:0]                    out_data;
    logic [IDX_W-1:0]                    out_idx;
    logic                                out_last;
    logic                                out_sat;
    logic                                busy;

    modport master (
        output in_valid, bias_flat, x_flat, w_flat, act_sel, mask_flat, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, out_sat, busy
    );

    modport slave (
        input  in_valid, bias_flat, x_flat, w_flat, act_sel, mask_flat, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, out_sat, busy
    );
endinterface

// File: rtl/neuron_layer_mac.sv
// Multi-neuron fixed-point dot-product layer: LANES MACs per cycle over a shared input
// vector, per-neuron bias, masked-group skipping, round/saturate and runtime activation.
module neuron_layer_mac #(
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned LANES       = 2,
    parameter int unsigned X_W         = 8,
    parameter int unsigned W_W         = 8,
    parameter int unsigned B_W         = 32,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned X_FRAC      = 4,
    parameter int unsigned W_FRAC      = 4,
    parameter int unsigned B_FRAC      = 8,
    parameter int unsigned OUT_FRAC    = 8,
    parameter int unsigned GUARD_BITS  = 2
) (
    input logic               clk,
    input logic               rst_n,
    neuron_layer_mac_if.slave bus_io
);
    localparam int P_FRAC = int'(X_FRAC + W_FRAC);
    localparam int SH     = P_FRAC - int'(OUT_FRAC);
    localparam int BSH    = P_FRAC - int'(B_FRAC);
    localparam int G_MAX  = int'(NUM_INPUTS / LANES);
    localparam int IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int GRP_W  = $clog2(G_MAX + 1);
    localparam int PROD_W = int'(X_W + W_W);
    localparam int ACC_A  = PROD_W + $clog2(NUM_INPUTS) + int'(GUARD_BITS);
    localparam int ACC_B  = int'(B_W) + BSH + 1;
    localparam int ACC_W  = (ACC_A > ACC_B) ? ACC_A : ACC_B;
    localparam int RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] RND_C   = (RND_W'(1) << SH) >> 1;
    localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [RND_W-1:0] OUT_MIN = RND_W'(-(2 ** (OUT_W - 1)));
    localparam logic signed [OUT_W-1:0] HT_MAX  = OUT_W'(2 ** OUT_FRAC);
    localparam logic signed [OUT_W-1:0] HT_MIN  = OUT_W'(-(2 ** OUT_FRAC));
    localparam logic [IDX_W-1:0]        LAST_N  = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {StIdle, StMac, StAct, StOut} state_e;

    state_e state_q, state_d;

    logic [NUM_INPUTS*X_W-1:0]             x_q, x_d;
    logic [NUM_NEURONS*NUM_INPUTS*W_W-1:0] w_q, w_d;
    logic [NUM_NEURONS*B_W-1:0]            bias_q, bias_d;
    logic [1:0]                            act_q, act_d;
    logic [NUM_INPUTS-1:0]                 mask_q, mask_d;
    logic [IDX_W-1:0]                      n_q, n_d;
    logic [GRP_W-1:0]                      grp_q, grp_d;
    logic signed [ACC_W-1:0]               acc_q, acc_d;
    logic [OUT_W-1:0]                      out_data_q, out_data_d;
    logic [IDX_W-1:0]                      out_idx_q, out_idx_d;
    logic                                  out_last_q, out_last_d;
    logic                                  out_sat_q, out_sat_d;

    logic [G_MAX-1:0]         grp_act;
    logic                     cur_found, more;
    logic [GRP_W-1:0]         cur_grp;
    logic signed [PROD_W-1:0] prod [LANES];
    logic signed [ACC_W-1:0]  lane_sum;
    logic [IDX_W-1:0]         n_nxt;
    logic signed [B_W-1:0]    bias_sel;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [RND_W-1:0]  rnd, shr;
    logic signed [OUT_W-1:0]  sat_v, act_v;
    logic                     sat_c, act_sat;

    // Pick the first active group at or after the cursor; 'more' says another one follows.
    always_comb begin
        cur_found = 1'b0;
        cur_grp   = '0;
        more      = 1'b0;
        for (int g = 0; g < G_MAX; g++) begin
            grp_act[g] = |mask_q[g*LANES +: LANES];
            if (grp_act[g] && (g >= int'(grp_q))) begin
                if (!cur_found) begin
                    cur_found = 1'b1;
                    cur_grp   = GRP_W'(g);
                end else begin
                    more = 1'b1;
                end
            end
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            prod[l] = '0;
            if (mask_q[int'(cur_grp) * LANES + l]) begin
                prod[l] = $signed(x_q[(int'(cur_grp) * LANES + l) * X_W +: X_W]) *
                          $signed(w_q[(int'(n_q) * NUM_INPUTS + int'(cur_grp) * LANES + l) * W_W
                                      +: W_W]);
            end
            lane_sum = lane_sum + ACC_W'(prod[l]);
        end
    end

    always_comb begin
        n_nxt    = n_q + IDX_W'(1);
        bias_sel = (state_q == StIdle) ? bus_io.bias_flat[B_W-1:0]
                                       : bias_q[int'(n_nxt) * B_W +: B_W];
        bias_ext = ACC_W'(bias_sel) <<< BSH;
    end

    // Round half up, saturate to OUT_W, then apply the selected activation.
    always_comb begin
        rnd   = RND_W'(acc_q) + RND_C;
        shr   = rnd >>> SH;
        sat_c = 1'b0;
        if (shr > OUT_MAX) begin
            sat_v = OUT_MAX[OUT_W-1:0];
            sat_c = 1'b1;
        end else if (shr < OUT_MIN) begin
            sat_v = OUT_MIN[OUT_W-1:0];
            sat_c = 1'b1;
        end else begin
            sat_v = shr[OUT_W-1:0];
        end
        act_v   = sat_v;
        act_sat = sat_c;
        case (act_q)
            2'd1: if (sat_v < 0) act_v = '0;
            2'd2: if (sat_v < 0) act_v = sat_v >>> 3;
            2'd3: begin
                if (sat_v > HT_MAX) begin
                    act_v   = HT_MAX;
                    act_sat = 1'b1;
                end else if (sat_v < HT_MIN) begin
                    act_v   = HT_MIN;
                    act_sat = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus_io.in_valid) state_d = StMac;
            StMac:  if (!cur_found || !more) state_d = StAct;
            StAct:  state_d = StOut;
            StOut:  if (bus_io.out_ready) state_d = out_last_q ? StIdle : StMac;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_io.in_ready  = (state_q == StIdle);
        bus_io.busy      = (state_q != StIdle);
        bus_io.out_valid = (state_q == StOut);
        bus_io.out_data  = out_data_q;
        bus_io.out_idx   = out_idx_q;
        bus_io.out_last  = out_last_q;
        bus_io.out_sat   = out_sat_q;
    end

    always_comb begin
        x_d        = x_q;
        w_d        = w_q;
        bias_d     = bias_q;
        act_d      = act_q;
        mask_d     = mask_q;
        n_d        = n_q;
        grp_d      = grp_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        out_sat_d  = out_sat_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    x_d    = bus_io.x_flat;
                    w_d    = bus_io.w_flat;
                    bias_d = bus_io.bias_flat;
                    act_d  = bus_io.act_sel;
                    mask_d = bus_io.mask_flat;
                    n_d    = '0;
                    grp_d  = '0;
                    acc_d  = bias_ext;
                end
            end
            StMac: begin
                if (cur_found) begin
                    acc_d = acc_q + lane_sum;
                    grp_d = cur_grp + GRP_W'(1);
                end
            end
            StAct: begin
                out_data_d = act_v;
                out_idx_d  = n_q;
                out_last_d = (n_q == LAST_N);
                out_sat_d  = act_sat;
            end
            StOut: begin
                if (bus_io.out_ready && !out_last_q) begin
                    n_d   = n_nxt;
                    grp_d = '0;
                    acc_d = bias_ext;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            w_q        <= '0;
            bias_q     <= '0;
            act_q      <= '0;
            mask_q     <= '0;
            n_q        <= '0;
            grp_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
            out_sat_q  <= 1'b0;
        end else begin
            x_q        <= x_d;
            w_q        <= w_d;
            bias_q     <= bias_d;
            act_q      <= act_d;
            mask_q     <= mask_d;
            n_q        <= n_d;
            grp_q      <= grp_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
            out_sat_q  <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_neuron_layer_mac.sv
// Directed bench for neuron_layer_mac: default-parameter DUT plus an OUT_FRAC=4 copy
// driven in lockstep; sel chooses which one is observed.
module tb_neuron_layer_mac;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    logic sel   = 1'b0;

    logic         tb_in_valid;
    logic         tb_out_ready;
    logic [127:0] tb_bias;
    logic [63:0]  tb_x;
    logic [255:0] tb_w;
    logic [1:0]   tb_act;
    logic [7:0]   tb_mask;

    neuron_layer_mac_if b1 ();
    neuron_layer_mac_if b2 ();

    assign b1.in_valid  = tb_in_valid;
    assign b1.out_ready = tb_out_ready;
    assign b1.bias_flat = tb_bias;
    assign b1.x_flat    = tb_x;
    assign b1.w_flat    = tb_w;
    assign b1.act_sel   = tb_act;
    assign b1.mask_flat = tb_mask;
    assign b2.in_valid  = tb_in_valid;
    assign b2.out_ready = tb_out_ready;
    assign b2.bias_flat = tb_bias;
    assign b2.x_flat    = tb_x;
    assign b2.w_flat    = tb_w;
    assign b2.act_sel   = tb_act;
    assign b2.mask_flat = tb_mask;

    neuron_layer_mac u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(b1)
    );

    neuron_layer_mac #(.OUT_FRAC(4)) u_dut_f4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(b2)
    );

    logic        o_valid, o_last, o_sat, o_busy, o_in_ready;
    logic [15:0] o_data;
    logic [1:0]  o_idx;
    assign o_valid    = sel ? b2.out_valid : b1.out_valid;
    assign o_last     = sel ? b2.out_last  : b1.out_last;
    assign o_sat      = sel ? b2.out_sat   : b1.out_sat;
    assign o_busy     = sel ? b2.busy      : b1.busy;
    assign o_in_ready = sel ? b2.in_ready  : b1.in_ready;
    assign o_data     = sel ? b2.out_data  : b1.out_data;
    assign o_idx      = sel ? b2.out_idx   : b1.out_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges counted from the MAC-entry edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (!o_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic load(input logic [7:0] xv, input logic [7:0] wv, input logic [31:0] bv,
                        input logic [7:0] m, input logic [1:0] a);
        for (int i = 0; i < 8; i++) tb_x[i*8 +: 8] = xv;
        for (int i = 0; i < 32; i++) tb_w[i*8 +: 8] = wv;
        for (int n = 0; n < 4; n++) tb_bias[n*32 +: 32] = bv;
        tb_mask = m;
        tb_act  = a;
    endtask

    task automatic check_res(input string tag, input int n, input logic [15:0] ed,
                             input int elat, input int lat, input logic esat);
        chk($sformatf("%s lat n%0d", tag, n), 32'(lat), 32'(elat));
        chk($sformatf("%s data n%0d", tag, n), 32'(o_data), 32'(ed));
        chk($sformatf("%s idx n%0d", tag, n), 32'(o_idx), 32'(n));
        chk($sformatf("%s last n%0d", tag, n), 32'(o_last), 32'(n == 3));
        chk($sformatf("%s sat n%0d", tag, n), 32'(o_sat), 32'(esat));
    endtask

    task automatic run_txn(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3, input int elat,
                           input logic esat);
        logic [15:0] ed [4];
        int          lat;
        ed[0] = e0;
        ed[1] = e1;
        ed[2] = e2;
        ed[3] = e3;
        chk({tag, " in_ready pre"}, 32'(o_in_ready), 32'd1);
        tb_in_valid = 1'b1;
        step();
        tb_in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            wait_out(lat);
            check_res(tag, n, ed[n], elat, lat, esat);
            step();
        end
        chk({tag, " valid post"}, 32'(o_valid), 32'd0);
        chk({tag, " in_ready post"}, 32'(o_in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b1;
        load(8'h10, 8'h10, 32'h0, 8'hFF, 2'd0);
        rst_n = 1'b0;
        #3;
        chk("rst out_valid", 32'(o_valid), 32'd0);
        chk("rst out_data", 32'(o_data), 32'd0);
        chk("rst out_idx", 32'(o_idx), 32'd0);
        chk("rst out_last", 32'(o_last), 32'd0);
        chk("rst out_sat", 32'(o_sat), 32'd0);
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst in_ready", 32'(o_in_ready), 32'd1);
        #10;
        rst_n = 1'b1;
        step();

        run_txn("dflt", 16'h0800, 16'h0800, 16'h0800, 16'h0800, 5, 1'b0);

        load(8'h10, 8'h10, 32'h0, 8'h0F, 2'd0);
        run_txn("mask0F", 16'h0400, 16'h0400, 16'h0400, 16'h0400, 3, 1'b0);

        load(8'h10, 8'h10, 32'h0, 8'h00, 2'd0);
        for (int n = 0; n < 4; n++) tb_bias[n*32 +: 32] = 32'(n) << 8;
        run_txn("mask00", 16'h0000, 16'h0100, 16'h0200, 16'h0300, 2, 1'b0);

        load(8'h7F, 8'h7F, 32'h7FFFFFFF, 8'hFF, 2'd0);
        run_txn("satpos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 5, 1'b1);
        load(8'h7F, 8'h81, 32'h80000000, 8'hFF, 2'd0);
        run_txn("satneg", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 5, 1'b1);

        load(8'h10, 8'hE0, 32'h0, 8'h01, 2'd0);
        run_txn("ident", 16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00, 2, 1'b0);
        load(8'h10, 8'hE0, 32'h0, 8'h01, 2'd1);
        run_txn("relu", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2, 1'b0);
        load(8'h10, 8'hE0, 32'h0, 8'h01, 2'd2);
        run_txn("leaky", 16'hFFC0, 16'hFFC0, 16'hFFC0, 16'hFFC0, 2, 1'b0);
        load(8'h10, 8'hE0, 32'h0, 8'h01, 2'd3);
        run_txn("htanh", 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 2, 1'b1);

        // Backpressure on neuron 1 while upstream inputs wiggle.
        load(8'h10, 8'h10, 32'h0, 8'hFF, 2'd0);
        tb_in_valid = 1'b1;
        step();
        tb_in_valid = 1'b0;
        wait_out(lat);
        check_res("bp", 0, 16'h0800, 5, lat, 1'b0);
        step();
        tb_out_ready = 1'b0;
        wait_out(lat);
        check_res("bp", 1, 16'h0800, 5, lat, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tb_in_valid = ~tb_in_valid;
            tb_x        = 64'(k) * 64'h0101_0101_0101_0101;
            step();
            chk("bp hold valid", 32'(o_valid), 32'd1);
            chk("bp hold data", 32'(o_data), 32'h0800);
            chk("bp hold idx", 32'(o_idx), 32'd1);
            chk("bp busy", 32'(o_busy), 32'd1);
            chk("bp in_ready", 32'(o_in_ready), 32'd0);
        end
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b1;
        step();
        for (int n = 2; n < 4; n++) begin
            wait_out(lat);
            check_res("bp", n, 16'h0800, 5, lat, 1'b0);
            step();
        end
        chk("bp idle", 32'(o_in_ready), 32'd1);

        // Rounding on the OUT_FRAC=4 instance: 0x188 (1.53125) -> 0x19.
        sel = 1'b1;
        load(8'h10, 8'h10, 32'h188, 8'h00, 2'd0);
        run_txn("f4rnd", 16'h0019, 16'h0019, 16'h0019, 16'h0019, 2, 1'b0);
        sel = 1'b0;

        // Asynchronous reset during MAC of neuron 2.
        load(8'h10, 8'h10, 32'h0, 8'hFF, 2'd0);
        tb_in_valid = 1'b1;
        step();
        tb_in_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            wait_out(lat);
            check_res("prerst", n, 16'h0800, 5, lat, 1'b0);
            step();
        end
        step();
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", 32'(o_valid), 32'd0);
        chk("mid rst out_data", 32'(o_data), 32'd0);
        chk("mid rst out_idx", 32'(o_idx), 32'd0);
        chk("mid rst out_last", 32'(o_last), 32'd0);
        chk("mid rst out_sat", 32'(o_sat), 32'd0);
        chk("mid rst busy", 32'(o_busy), 32'd0);
        chk("mid rst in_ready", 32'(o_in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        step();
        run_txn("postrst", 16'h0800, 16'h0800, 16'h0800, 16'h0800, 5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/neuron_layer_mac.md
Name: neuron_layer_mac

Overview:
- Multi-neuron, multi-lane successor to the single-neuron serial MAC.
- Computes NUM_NEURONS fixed-point dot products over one shared input vector, LANES products per cycle.
- Per-neuron bias; masked-group skipping; runtime activation; rounding and saturation.
- Results stream out one neuron at a time with valid/ready backpressure. Sits between the input-vector buffer and the next layer's input FIFO.

Parameters:
NUM_INPUTS, 8, inputs per neuron; must be a multiple of LANES
NUM_NEURONS, 4, neurons per transaction, all sharing x_flat
LANES, 2, parallel multipliers; G_MAX = NUM_INPUTS/LANES groups
X_W, 8, signed input width
W_W, 8, signed weight width
B_W, 32, signed bias width
OUT_W, 16, signed output width
X_FRAC, 4, input fractional bits
W_FRAC, 4, weight fractional bits
B_FRAC, 8, bias fractional bits; must be <= P_FRAC = X_FRAC+W_FRAC
OUT_FRAC, 8, output fractional bits; must be <= P_FRAC
GUARD_BITS, 2, extra accumulator headroom

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  transaction request
in_ready  out  1  high iff FSM is IDLE
bias_flat  in  NUM_NEURONS*B_W  bias of neuron n at slice n
x_flat  in  NUM_INPUTS*X_W  input i at slice i
w_flat  in  NUM_NEURONS*NUM_INPUTS*W_W  weight (n,i) at slice n*NUM_INPUTS+i
act_sel  in  2  0 identity, 1 ReLU, 2 leaky ReLU, 3 hard-tanh
mask_flat  in  NUM_INPUTS  bit i = 1 enables input i
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  OUT_W  activated result
out_idx  out  clog2(NUM_NEURONS) (min 1)  neuron index of out_data
out_last  out  1  high with the result for neuron NUM_NEURONS-1
out_sat  out  1  saturation occurred for this result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low): FSM goes to IDLE. out_valid, out_data, out_idx, out_last, out_sat and busy are 0; in_ready is 1. Reset mid-transaction aborts it with no output.
- Acceptance: edge with in_valid && in_ready. Latches bias_flat, x_flat, w_flat, act_sel and mask_flat, sets neuron n=0 and enters MAC. Later changes on these inputs are ignored until the next IDLE.
- Accumulator: ACC_W = max(X_W+W_W+clog2(NUM_INPUTS)+GUARD_BITS, B_W+P_FRAC-B_FRAC+1), signed.
  - Initialised to bias[n] << (P_FRAC-B_FRAC), sign-extended, on the edge entering MAC.
- A group is active if any of its LANES mask bits is 1. Let G = number of active groups.
- MAC state: one active group per cycle, in ascending order; inactive groups consume no cycles. Masked lanes inside an active group contribute 0.
  - Occupies max(G,1) cycles; with G=0 the accumulator keeps the bias.
- ACT state (1 cycle):
  - Round: add 1 << (P_FRAC-OUT_FRAC-1) when the shift is nonzero, then arithmetic shift right by P_FRAC-OUT_FRAC.
  - Saturate to the OUT_W signed range; out_sat = 1 if clipped.
  - Activate:
    - ReLU: negative -> 0.
    - Leaky ReLU: negative -> arithmetic >>3 (floor).
    - Hard-tanh: clamp to [-(1<<OUT_FRAC), +(1<<OUT_FRAC)]; sets out_sat if this clamp clips.
  - Registers out_data, out_idx=n, out_last=(n==NUM_NEURONS-1), out_valid=1; enters OUT.
- Latency: out_valid rises max(G,1)+1 edges after the edge entering MAC.
- OUT state: out_valid and all payload outputs hold stable until out_ready. out_ready while out_valid is low is ignored.
- On the out handshake edge:
  - If not last: n++, reload accumulator with the next bias, enter MAC, out_valid=0.
  - If last: go to IDLE, out_valid=0, in_ready=1 next cycle.
- No overlap: a new transaction is accepted only in IDLE, i.e. at least one cycle after the last result handshake.

Test Plan:
- Defaults, x all 0x10 (1.0), w all 0x10, mask 0xFF, bias 0, act 0 -> four results of 0x0800 (8.0), out_idx 0..3, out_last only on idx 3; first out_valid 5 edges after accept; out_sat 0.
- mask 0x0F, same data -> G=2, each result 0x0400, out_valid 3 edges after MAC entry; mask 0x00, bias[n]=n<<8 -> results 0x0000, 0x0100, 0x0200, 0x0300, each 2 edges after MAC entry.
- x all 0x7F, w all 0x7F, bias 0x7FFFFFFF, act 0 -> out_data 0x7FFF, out_sat 1; negate weights and set bias 0x80000000 -> 0x8000, out_sat 1.
- Activations on a single -2.0 result (x0=0x10, w0=0xE0, mask 0x01, bias 0): act 1 -> 0x0000; act 2 -> 0xFFC0; act 3 -> 0xFF00 with out_sat 1.
- Backpressure: hold out_ready low for 10 cycles on neuron 1 -> out_data/out_idx stable, no further MAC progress, busy 1, in_ready 0; toggling in_valid and changing x_flat meanwhile has no effect on results.
- OUT_FRAC=4 override, result 0x0188 in P_FRAC -> 0x0019 (rounds half up); then assert rst_n low during MAC of neuron 2 -> all outputs 0 and in_ready 1 immediately; next transaction completes normally.
